mesh_nic: RTL and testbench

MESH_NIC -- requirements
Module: mesh_nic

---
 rtl/mesh_nic.sv | 116 +++++++++++
 tb/tb_mesh_nic.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_nic.sv
// mesh_nic: processor-side network interface for one mesh router port.
// One-entry output buffer (processor -> router) and one-entry input buffer
// (router -> processor), both accessed through a 2-bit register select.
// Optional build macro MESH_NIC_POLARITY_EN: when defined, a buffered packet
// is only offered to the router while the router's even/odd phase matches
// the packet's virtual-channel bit (its MSB).
module mesh_nic #(
    parameter int PACKET_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              addr,
    input  logic [PACKET_WIDTH-1:0] d_in,
    output logic [PACKET_WIDTH-1:0] d_out,
    input  logic                    nicEn,
    input  logic                    nicWrEn,
    output logic                    pesi,
    input  logic                    peri,
    output logic [PACKET_WIDTH-1:0] pedi,
    input  logic                    peso,
    output logic                    pero,
    input  logic [PACKET_WIDTH-1:0] pedo,
    input  logic                    polarity
);

    localparam logic [1:0] ADDR_IBUF  = 2'b00;
    localparam logic [1:0] ADDR_ISTAT = 2'b01;
    localparam logic [1:0] ADDR_OBUF  = 2'b10;
    localparam logic [1:0] ADDR_OSTAT = 2'b11;

    logic [PACKET_WIDTH-1:0] obuf_q, obuf_d;
    logic [PACKET_WIDTH-1:0] ibuf_q, ibuf_d;
    logic                    obuf_full_q, obuf_full_d;
    logic                    ibuf_full_q, ibuf_full_d;

    logic cpu_rd;
    logic cpu_wr;
    logic send_ok;
    logic tx_fire;
    logic rx_fire;

    assign cpu_rd = nicEn & ~nicWrEn;
    assign cpu_wr = nicEn & nicWrEn;

`ifdef MESH_NIC_POLARITY_EN
    // Hold the packet until the router phase matches its virtual channel.
    assign send_ok = (polarity == obuf_q[PACKET_WIDTH-1]);
`else
    logic unused_polarity;
    assign unused_polarity = polarity;
    assign send_ok = 1'b1;
`endif

    assign pesi    = obuf_full_q & send_ok;
    assign pedi    = obuf_q;
    assign pero    = ~ibuf_full_q;
    assign tx_fire = pesi & peri;
    assign rx_fire = peso & pero;

    // Output channel: load on processor write when empty, drain on handshake.
    // A write in the same cycle as a drain sees the buffer full and is dropped.
    always_comb begin
        obuf_d      = obuf_q;
        obuf_full_d = obuf_full_q;
        if (tx_fire) begin
            obuf_full_d = 1'b0;
        end else if (cpu_wr && (addr == ADDR_OBUF) && !obuf_full_q) begin
            obuf_d      = d_in;
            obuf_full_d = 1'b1;
        end
    end

    // Input channel: read of the data register clears the flag; a router
    // delivery (only possible while empty) takes priority so it is never lost.
    always_comb begin
        ibuf_d      = ibuf_q;
        ibuf_full_d = ibuf_full_q;
        if (cpu_rd && (addr == ADDR_IBUF)) begin
            ibuf_full_d = 1'b0;
        end
        if (rx_fire) begin
            ibuf_d      = pedo;
            ibuf_full_d = 1'b1;
        end
    end

    // Processor read mux; zero whenever no read is in progress.
    always_comb begin
        d_out = '0;
        if (cpu_rd) begin
            case (addr)
                ADDR_IBUF:  d_out = ibuf_q;
                ADDR_ISTAT: d_out = {{(PACKET_WIDTH-1){1'b0}}, ibuf_full_q};
                ADDR_OBUF:  d_out = '0;
                ADDR_OSTAT: d_out = {{(PACKET_WIDTH-1){1'b0}}, obuf_full_q};
                default:    d_out = '0;
            endcase
        end
    end

    // Buffer and flag registers; reset discards any buffered packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            obuf_q      <= '0;
            ibuf_q      <= '0;
            obuf_full_q <= 1'b0;
            ibuf_full_q <= 1'b0;
        end else begin
            obuf_q      <= obuf_d;
            ibuf_q      <= ibuf_d;
            obuf_full_q <= obuf_full_d;
            ibuf_full_q <= ibuf_full_d;
        end
    end

endmodule

// File: tb/tb_mesh_nic.sv
// Scoreboard bench for mesh_nic: stimulus pushes expected read data and
// expected router-bound packets into queues; a negedge monitor pops and
// compares whenever a processor read or a router handshake is presented.
module tb_mesh_nic;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   addr;
    logic [W-1:0] d_in;
    logic [W-1:0] d_out;
    logic         nicEn;
    logic         nicWrEn;
    logic         pesi;
    logic         peri;
    logic [W-1:0] pedi;
    logic         peso;
    logic         pero;
    logic [W-1:0] pedo;
    logic         polarity;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] rd_q[$];
    logic [W-1:0] tx_q[$];

    mesh_nic #(.PACKET_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .pesi(pesi), .peri(peri), .pedi(pedi),
        .peso(peso), .pero(pero), .pedo(pedo), .polarity(polarity)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, required finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented read and every router handshake.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (reset === 1'b1 && nicEn === 1'b1 && nicWrEn === 1'b0) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got %h expected no read", d_out);
            end else begin
                e = rd_q.pop_front();
                chk("rd_data", d_out, e);
            end
        end
        if (reset === 1'b1 && pesi === 1'b1 && peri === 1'b1) begin
            if (tx_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx_unexpected: got %h expected no transfer", pedi);
            end else begin
                e = tx_q.pop_front();
                chk("tx_pkt", pedi, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [W-1:0] exp);
        addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
        rd_q.push_back(exp);
        step();
        nicEn = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] data);
        addr = a; d_in = data; nicEn = 1'b1; nicWrEn = 1'b1;
        step();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    initial begin
        logic exp_pesi;
        reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        peri = 1'b0; peso = 1'b1; pedo = 64'hFFFF; polarity = 1'b0;

        // Reset held with router offering a packet.
        @(negedge clk); @(negedge clk);
        chk("rst_pero", {63'd0, pero}, 64'd1);
        chk("rst_pesi", {63'd0, pesi}, 64'd0);
        chk("rst_dout", d_out, 64'd0);
        chk("rst_pedi", pedi, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1; peso = 1'b0;
        rd(2'b01, 64'd0);
        rd(2'b00, 64'd0);

        // Output channel blocked by router, then drained.
        wr(2'b10, 64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("obuf_pesi_held", {63'd0, pesi}, 64'd1);
            chk("obuf_pedi_held", pedi, 64'h0123_4567_89AB_CDEF);
            step();
        end
        rd(2'b11, 64'd1);
        wr(2'b10, 64'h1);
        rd(2'b11, 64'd1);
        @(negedge clk);
        chk("obuf_drop_pedi", pedi, 64'h0123_4567_89AB_CDEF);
        tx_q.push_back(64'h0123_4567_89AB_CDEF);
        peri = 1'b1;
        step();
        peri = 1'b0;
        @(negedge clk);
        chk("obuf_drained_pesi", {63'd0, pesi}, 64'd0);
        rd(2'b11, 64'd0);

        // Write and transfer in the same cycle: write dropped.
        wr(2'b10, 64'hAAAA_0000_0000_1111);
        tx_q.push_back(64'hAAAA_0000_0000_1111);
        addr = 2'b10; d_in = 64'hBBBB_0000_0000_2222; nicEn = 1'b1; nicWrEn = 1'b1; peri = 1'b1;
        step();
        nicEn = 1'b0; nicWrEn = 1'b0; peri = 1'b0;
        @(negedge clk);
        chk("simul_pesi", {63'd0, pesi}, 64'd0);
        chk("simul_pedi", pedi, 64'hAAAA_0000_0000_1111);
        rd(2'b11, 64'd0);

        // Input channel: accept, refuse while full, read-to-clear.
        peso = 1'b1; pedo = 64'hDEAD_BEEF;
        step();
        peso = 1'b0;
        @(negedge clk);
        chk("ibuf_pero_full", {63'd0, pero}, 64'd0);
        rd(2'b01, 64'd1);
        peso = 1'b1; pedo = 64'h5;
        step();
        peso = 1'b0;
        rd(2'b00, 64'hDEAD_BEEF);
        @(negedge clk);
        chk("ibuf_pero_free", {63'd0, pero}, 64'd1);
        step();
        // Delivery right after a clearing read.
        rd(2'b00, 64'hDEAD_BEEF);
        peso = 1'b1; pedo = 64'h77;
        step();
        peso = 1'b0;
        @(negedge clk);
        chk("b2b_pero", {63'd0, pero}, 64'd0);
        rd(2'b00, 64'h77);
        rd(2'b00, 64'h77);
        rd(2'b01, 64'd0);

        // Ignored writes, addr-10 reads zero, idle/write d_out zero.
        wr(2'b00, 64'h1234);
        wr(2'b01, 64'h1);
        wr(2'b11, 64'h1);
        rd(2'b01, 64'd0);
        rd(2'b11, 64'd0);
        rd(2'b00, 64'h77);
        rd(2'b10, 64'd0);
        @(negedge clk);
        chk("idle_dout", d_out, 64'd0);
        addr = 2'b00; nicEn = 1'b1; nicWrEn = 1'b1; d_in = 64'h99;
        @(negedge clk);
        chk("wr_dout", d_out, 64'd0);
        @(posedge clk); #1;
        nicEn = 1'b0; nicWrEn = 1'b0;

        // Polarity gating on a packet with virtual-channel bit set.
        wr(2'b10, 64'h8000_0000_0000_00AA);
        for (int i = 0; i < 4; i++) begin
            polarity = i[0];
`ifdef MESH_NIC_POLARITY_EN
            exp_pesi = i[0];
`else
            exp_pesi = 1'b1;
`endif
            @(negedge clk);
            chk("polarity_pesi", {63'd0, pesi}, {63'd0, exp_pesi});
            step();
        end
        polarity = 1'b1; peri = 1'b1;
        tx_q.push_back(64'h8000_0000_0000_00AA);
        step();
        peri = 1'b0; polarity = 1'b0;
        @(negedge clk);
        chk("polarity_drained", {63'd0, pesi}, 64'd0);

        // Reset mid-transfer discards both buffers.
        wr(2'b10, 64'hCAFE);
        peso = 1'b1; pedo = 64'hF00D;
        step();
        peso = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midrst_pesi", {63'd0, pesi}, 64'd0);
        chk("midrst_pero", {63'd0, pero}, 64'd1);
        chk("midrst_pedi", pedi, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        rd(2'b01, 64'd0);
        rd(2'b11, 64'd0);
        rd(2'b00, 64'd0);
        // First write after reset is accepted at the first edge.
        wr(2'b10, 64'h42);
        rd(2'b11, 64'd1);

        step();
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
        chk("tx_q_drained", 64'(tx_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
